// File: rtl/last_beat_tagger.sv
// -----------------------------------------------------------------------------
// last_beat_tagger
//
// Watches the address stream of AXI write beats landing in a ring of RX
// buffers. For each beat it tells the downstream consumer whether the beat
// before it was the last beat of a packet. A packet is tied off either by the
// start beat of the next packet or by a DMA-complete pulse from the PS.
// Completions are counted into a small pending counter and retired one per
// cycle. Retiring takes priority over accepting a beat.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   i_addr_data     beat address
//   i_addr_valid    beat address valid
//   i_addr_ready    beat address accepted (combinational)
//   i_dma_complete  one-cycle pulse, one packet DMA finished; no backpressure
//   o_last          the previous beat was the last beat of its packet
//   o_last_valid    o_last / o_pkt_beats are valid
//   i_last_ready    downstream accepts o_last
//   o_pkt_beats     beat count of the packet that was tied off (when o_last=1)
//   o_err_spurious  pulse: completion arrived with no packet outstanding
//   o_err_orphan    pulse: non-start beat arrived with no packet outstanding
//   o_err_overflow  sticky: completion arrived with the pending counter full
// -----------------------------------------------------------------------------
module last_beat_tagger #(
  parameter int ADDR_WIDTH     = 12,
  parameter int BASE_ADDR      = 0,
  parameter int BUF_STRIDE     = 2048,
  parameter int NUM_BUFS       = 1,
  parameter int CNT_WIDTH      = 2,
  parameter int BEAT_CNT_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     i_addr_data,
  input  logic                      i_addr_valid,
  output logic                      i_addr_ready,
  input  logic                      i_dma_complete,
  output logic                      o_last,
  output logic                      o_last_valid,
  input  logic                      i_last_ready,
  output logic [BEAT_CNT_WIDTH-1:0] o_pkt_beats,
  output logic                      o_err_spurious,
  output logic                      o_err_orphan,
  output logic                      o_err_overflow
);

  localparam int STRIDE_LG = $clog2(BUF_STRIDE);
  // One bit wider than the address so a ring covering the whole address
  // space still compares correctly.
  localparam logic [ADDR_WIDTH:0]       BUF_SPAN = (ADDR_WIDTH+1)'(NUM_BUFS * BUF_STRIDE);
  localparam logic [ADDR_WIDTH-1:0]     BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CNT_WIDTH:0]        CNT_ONE  = (CNT_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH:0]        MAX_OUT  = CNT_ONE << CNT_WIDTH;
  localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_ONE = BEAT_CNT_WIDTH'(1);
  localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_MAX = '1;

  logic [CNT_WIDTH:0]        start_q, start_d;
  logic [CNT_WIDTH:0]        done_q, done_d;
  logic [CNT_WIDTH:0]        pend_q, pend_d;
  logic [BEAT_CNT_WIDTH-1:0] cur_q, cur_d;
  logic                      last_q, last_d;
  logic                      valid_q, valid_d;
  logic [BEAT_CNT_WIDTH-1:0] beats_q, beats_d;
  logic                      spur_q, spur_d;
  logic                      orph_q, orph_d;
  logic                      ovf_q, ovf_d;

  logic [ADDR_WIDTH-1:0] off;
  logic                  is_start;
  logic [CNT_WIDTH:0]    outstanding;
  logic                  slot_free;
  logic                  retire;
  logic                  addr_ready;
  logic                  beat_acc;

  // Offset into the buffer ring, wrapping modulo the address space.
  assign off      = i_addr_data - BASE;
  assign is_start = ({1'b0, off} < BUF_SPAN) && (off[STRIDE_LG-1:0] == '0);

  assign outstanding = start_q - done_q;
  assign slot_free   = !valid_q || i_last_ready;
  assign retire      = (pend_q != '0) && slot_free;
  // Beats wait while a completion is pending so that a completion is always
  // applied before any beat that follows it.
  assign addr_ready  = slot_free && (pend_q == '0) && (outstanding != MAX_OUT);
  assign beat_acc    = i_addr_valid && addr_ready;

  always_comb begin
    start_d = start_q;
    done_d  = done_q;
    pend_d  = pend_q;
    cur_d   = cur_q;
    last_d  = last_q;
    valid_d = valid_q;
    beats_d = beats_q;
    spur_d  = 1'b0;
    orph_d  = 1'b0;
    ovf_d   = ovf_q;

    // Output slot drains when accepted; it is overwritten below if something
    // new is presented this cycle.
    if (slot_free) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      beats_d = '0;
    end

    if (retire) begin
      if (outstanding == CNT_ONE) begin
        done_d  = done_q + CNT_ONE;
        valid_d = 1'b1;
        last_d  = 1'b1;
        beats_d = cur_q;
        cur_d   = '0;
      end else if (outstanding != '0) begin
        // Packet was already tied off by a later start beat.
        done_d = done_q + CNT_ONE;
      end else begin
        spur_d = 1'b1;
      end
    end else if (beat_acc) begin
      if (is_start) begin
        start_d = start_q + CNT_ONE;
        cur_d   = BEAT_ONE;
        if (outstanding != '0) begin
          valid_d = 1'b1;
          last_d  = 1'b1;
          beats_d = cur_q;
        end
      end else if (outstanding != '0) begin
        valid_d = 1'b1;
        last_d  = 1'b0;
        beats_d = '0;
        if (cur_q != BEAT_MAX) begin
          cur_d = cur_q + BEAT_ONE;
        end
      end else begin
        orph_d = 1'b1;
      end
    end

    // Pending completions: a same-cycle arrival and retire cancel out.
    if (i_dma_complete && !retire) begin
      if (pend_q == MAX_OUT) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + CNT_ONE;
      end
    end else if (!i_dma_complete && retire) begin
      pend_d = pend_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= '0;
      done_q  <= '0;
      pend_q  <= '0;
      cur_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      beats_q <= '0;
      spur_q  <= 1'b0;
      orph_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      beats_q <= beats_d;
      spur_q  <= spur_d;
      orph_q  <= orph_d;
      ovf_q   <= ovf_d;
    end
  end

  assign i_addr_ready   = addr_ready;
  assign o_last         = last_q;
  assign o_last_valid   = valid_q;
  assign o_pkt_beats    = beats_q;
  assign o_err_spurious = spur_q;
  assign o_err_orphan   = orph_q;
  assign o_err_overflow = ovf_q;

endmodule

// File: tb/tb_last_beat_tagger.sv
// -----------------------------------------------------------------------------
// Testbench for last_beat_tagger: two RX buffers of 0x800 bytes in a 12-bit
// address space. A packet-level reference model (open packet count, pending
// completions, beats in the current packet) predicts every cycle.
// -----------------------------------------------------------------------------
module tb_last_beat_tagger;

  localparam int AW     = 12;
  localparam int BASE   = 0;
  localparam int STRIDE = 2048;
  localparam int NB     = 2;
  localparam int CW     = 2;
  localparam int BW     = 10;
  localparam int MAXO   = 4;
  localparam int BMAX   = 1023;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] i_addr_data;
  logic          i_addr_valid;
  logic          i_addr_ready;
  logic          i_dma_complete;
  logic          o_last;
  logic          o_last_valid;
  logic          i_last_ready;
  logic [BW-1:0] o_pkt_beats;
  logic          o_err_spurious;
  logic          o_err_orphan;
  logic          o_err_overflow;

  always #5 clk = ~clk;

  last_beat_tagger #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .BUF_STRIDE(STRIDE),
    .NUM_BUFS(NB), .CNT_WIDTH(CW), .BEAT_CNT_WIDTH(BW)
  ) dut (
    .clk(clk), .reset(reset),
    .i_addr_data(i_addr_data), .i_addr_valid(i_addr_valid), .i_addr_ready(i_addr_ready),
    .i_dma_complete(i_dma_complete),
    .o_last(o_last), .o_last_valid(o_last_valid), .i_last_ready(i_last_ready),
    .o_pkt_beats(o_pkt_beats),
    .o_err_spurious(o_err_spurious), .o_err_orphan(o_err_orphan),
    .o_err_overflow(o_err_overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model, in packet terms.
  int m_open;    // packets started and not yet completed
  int m_pend;    // completions waiting to be applied
  int m_cur;     // beats seen so far in the newest packet
  bit m_valid, m_last, m_sp, m_or, m_ov;
  int m_beats;
  bit exp_ready, obs_ready;
  logic [15:0] obs_vec, exp_vec;

  function automatic bit is_start(input logic [AW-1:0] a);
    int off;
    off = (int'(a) - BASE + (1 << AW)) % (1 << AW);
    return (off < NB * STRIDE) && (off % STRIDE == 0);
  endfunction

  // {ready, valid, last, beats-when-last, spurious, orphan, overflow}
  function automatic logic [15:0] dut_vec(input bit rdy);
    return {rdy, o_last_valid, o_last_valid & o_last,
            (o_last_valid && o_last) ? o_pkt_beats : 10'd0,
            o_err_spurious, o_err_orphan, o_err_overflow};
  endfunction

  function automatic logic [15:0] model_vec(input bit rdy);
    logic [9:0] b;
    b = (m_valid && m_last) ? 10'(m_beats) : 10'd0;
    return {rdy, m_valid, m_valid & m_last, b, m_sp, m_or, m_ov};
  endfunction

  task automatic model_reset();
    m_open = 0; m_pend = 0; m_cur = 0;
    m_valid = 0; m_last = 0; m_beats = 0;
    m_sp = 0; m_or = 0; m_ov = 0;
  endtask

  // One clock cycle: drive inputs, advance the model, capture DUT outputs.
  task automatic step(input bit v, input logic [AW-1:0] a, input bit c, input bit r);
    bit slot_free, retire, acc, pres, plast;
    int pbeats;
    i_addr_valid   = v;
    i_addr_data    = a;
    i_dma_complete = c;
    i_last_ready   = r;
    #1;
    obs_ready = i_addr_ready;

    slot_free = !m_valid || r;
    exp_ready = slot_free && (m_pend == 0) && (m_open != MAXO);
    retire    = (m_pend != 0) && slot_free;
    acc       = v && exp_ready;
    pres = 0; plast = 0; pbeats = 0;
    m_sp = 0; m_or = 0;
    if (retire) begin
      if (m_open == 1) begin
        m_open = 0; pres = 1; plast = 1; pbeats = m_cur; m_cur = 0;
      end else if (m_open >= 2) begin
        m_open = m_open - 1;
      end else begin
        m_sp = 1;
      end
    end else if (acc) begin
      if (is_start(a)) begin
        if (m_open > 0) begin pres = 1; plast = 1; pbeats = m_cur; end
        m_open = m_open + 1;
        m_cur  = 1;
      end else if (m_open > 0) begin
        pres = 1; plast = 0;
        if (m_cur < BMAX) m_cur = m_cur + 1;
      end else begin
        m_or = 1;
      end
    end
    if (pres) begin
      m_valid = 1; m_last = plast; m_beats = pbeats;
    end else if (slot_free) begin
      m_valid = 0; m_last = 0; m_beats = 0;
    end
    if (c && !retire) begin
      if (m_pend == MAXO) m_ov = 1;
      else m_pend = m_pend + 1;
    end else if (!c && retire) begin
      m_pend = m_pend - 1;
    end

    @(posedge clk);
    #1;
    i_addr_valid   = 1'b0;
    i_dma_complete = 1'b0;
    obs_vec = dut_vec(obs_ready);
    exp_vec = model_vec(exp_ready);
  endtask

  // Asserts reset between edges, samples outputs while it is held, releases.
  task automatic apply_reset();
    i_addr_valid = 1'b0; i_dma_complete = 1'b0; i_last_ready = 1'b1;
    i_addr_data = '0;
    reset = 1'b1;
    #2;
    obs_vec = dut_vec(i_addr_ready);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (obs_vec !== 16'h8000) begin
      errors++; $display("FAIL reset_during: got %h required %h", obs_vec, 16'h8000);
    end
    step(0, '0, 0, 1);
    checks++;
    if (obs_vec !== 16'h8000 || obs_vec !== exp_vec) begin
      errors++; $display("FAIL reset_after: got %h required %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_single_packet();
    logic [AW-1:0] addrs [4] = '{12'h000, 12'h004, 12'h008, 12'h00C};
    bit            vexp  [4] = '{0, 1, 1, 1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, addrs[i], 0, 1);
      checks++;
      if (obs_vec !== exp_vec || o_last_valid !== vexp[i] || (vexp[i] && o_last !== 1'b0)) begin
        errors++;
        $display("FAIL single_beat%0d: got %h valid=%b last=%b required %h valid=%b last=0",
                 i, obs_vec, o_last_valid, o_last, exp_vec, vexp[i]);
      end
    end
    step(0, '0, 1, 1);
    checks++;
    if (obs_vec !== exp_vec || o_last_valid !== 1'b0) begin
      errors++; $display("FAIL single_complete: got %h required %h", obs_vec, exp_vec);
    end
    step(0, '0, 0, 1);
    checks++;
    if (obs_vec !== exp_vec || o_last_valid !== 1'b1 || o_last !== 1'b1 || o_pkt_beats !== 10'd4) begin
      errors++;
      $display("FAIL single_last: got valid=%b last=%b beats=%0d required valid=1 last=1 beats=4",
               o_last_valid, o_last, o_pkt_beats);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [4] = '{12'h000, 12'h004, 12'h800, 12'h804};
    bit            vexp  [4] = '{0, 1, 1, 1};
    bit            lexp  [4] = '{0, 0, 1, 0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, addrs[i], 0, 1);
      checks++;
      if (obs_vec !== exp_vec || o_last_valid !== vexp[i] || (vexp[i] && o_last !== lexp[i]) ||
          (lexp[i] && o_pkt_beats !== 10'd2)) begin
        errors++;
        $display("FAIL b2b_beat%0d: got valid=%b last=%b beats=%0d required valid=%b last=%b",
                 i, o_last_valid, o_last, o_pkt_beats, vexp[i], lexp[i]);
      end
    end
    step(0, '0, 1, 1);
    step(0, '0, 1, 1);
    checks++;
    if (obs_vec !== exp_vec || o_last_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_first_silent: got %h required %h", obs_vec, exp_vec);
    end
    step(0, '0, 0, 1);
    checks++;
    if (obs_vec !== exp_vec || o_last_valid !== 1'b1 || o_last !== 1'b1 || o_pkt_beats !== 10'd2) begin
      errors++;
      $display("FAIL b2b_second_last: got valid=%b last=%b beats=%0d required 1 1 2",
               o_last_valid, o_last, o_pkt_beats);
    end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, (k % 2 == 1) ? 12'h800 : 12'h000, 0, 1);
      checks++;
      if (obs_vec !== exp_vec || obs_ready !== 1'b1) begin
        errors++; $display("FAIL fill_start%0d: got %h required %h", k, obs_vec, exp_vec);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(1, 12'h000, (k == 2), 1);
      checks++;
      if (obs_vec !== exp_vec || obs_ready !== 1'b0) begin
        errors++; $display("FAIL fill_blocked%0d: got ready=%b required 0", k, obs_ready);
      end
    end
    step(1, 12'h000, 0, 1);
    checks++;
    if (obs_vec !== exp_vec || obs_ready !== 1'b0) begin
      errors++; $display("FAIL fill_retire: got ready=%b required 0", obs_ready);
    end
    step(1, 12'h000, 0, 1);
    checks++;
    if (obs_vec !== exp_vec || obs_ready !== 1'b1 || o_last !== 1'b1 || o_pkt_beats !== 10'd1) begin
      errors++;
      $display("FAIL fill_resume: got ready=%b last=%b beats=%0d required 1 1 1",
               obs_ready, o_last, o_pkt_beats);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    step(1, 12'h000, 0, 1);
    step(1, 12'h004, 0, 1);
    for (int k = 0; k < 5; k++) begin
      step(k != 0, 12'h008, (k == 0), 0);
      checks++;
      if (obs_vec !== exp_vec || obs_ready !== 1'b0 || o_last_valid !== 1'b1 || o_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got ready=%b valid=%b last=%b required 0 1 0",
                 k, obs_ready, o_last_valid, o_last);
      end
    end
    step(0, '0, 0, 1);
    checks++;
    if (obs_vec !== exp_vec || o_last_valid !== 1'b1 || o_last !== 1'b1 || o_pkt_beats !== 10'd2) begin
      errors++;
      $display("FAIL bp_release: got valid=%b last=%b beats=%0d required 1 1 2",
               o_last_valid, o_last, o_pkt_beats);
    end
  endtask

  task automatic test_errors();
    apply_reset();
    step(0, '0, 1, 1);
    step(0, '0, 0, 1);
    checks++;
    if (obs_vec !== exp_vec || o_err_spurious !== 1'b1) begin
      errors++; $display("FAIL err_spurious: got %b required 1", o_err_spurious);
    end
    step(0, '0, 0, 1);
    checks++;
    if (obs_vec !== exp_vec || o_err_spurious !== 1'b0) begin
      errors++; $display("FAIL err_spurious_clear: got %b required 0", o_err_spurious);
    end
    apply_reset();
    step(1, 12'h004, 0, 1);
    checks++;
    if (obs_vec !== exp_vec || o_err_orphan !== 1'b1 || o_last_valid !== 1'b0) begin
      errors++; $display("FAIL err_orphan: got %b required 1", o_err_orphan);
    end
    step(0, '0, 0, 1);
    checks++;
    if (obs_vec !== exp_vec || o_err_orphan !== 1'b0) begin
      errors++; $display("FAIL err_orphan_clear: got %b required 0", o_err_orphan);
    end
    apply_reset();
    step(1, 12'h000, 0, 1);
    step(1, 12'h004, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, '0, 1, 0);
      checks++;
      if (obs_vec !== exp_vec || o_err_overflow !== (k == 4)) begin
        errors++;
        $display("FAIL err_overflow%0d: got %b required %b", k, o_err_overflow, (k == 4));
      end
    end
    for (int k = 0; k < 6; k++) begin
      step(0, '0, 0, 1);
    end
    checks++;
    if (obs_vec !== exp_vec || o_err_overflow !== 1'b1) begin
      errors++; $display("FAIL err_overflow_sticky: got %b required 1", o_err_overflow);
    end
    apply_reset();
    checks++;
    if (obs_vec !== 16'h8000) begin
      errors++; $display("FAIL err_reset_clear: got %h required %h", obs_vec, 16'h8000);
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    step(1, 12'h000, 0, 1);
    step(1, 12'h004, 0, 1);
    apply_reset();
    checks++;
    if (obs_vec !== 16'h8000) begin
      errors++; $display("FAIL midrst_clear: got %h required %h", obs_vec, 16'h8000);
    end
    step(1, 12'h000, 0, 1);
    checks++;
    if (obs_vec !== exp_vec || obs_ready !== 1'b1 || o_last_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_first_start: got ready=%b valid=%b required 1 0", obs_ready, o_last_valid);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    step(1, 12'h000, 0, 1);
    for (int k = 0; k < BMAX + 8; k++) begin
      step(1, 12'h004, 0, 1);
    end
    step(0, '0, 1, 1);
    step(0, '0, 0, 1);
    checks++;
    if (obs_vec !== exp_vec || o_last !== 1'b1 || o_pkt_beats !== 10'd1023) begin
      errors++; $display("FAIL beat_saturate: got beats=%0d required 1023", o_pkt_beats);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int sel;
    int shown = 0;
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0)      a = 12'h000;
      else if (sel == 1) a = 12'h800;
      else               a = 12'($urandom_range(0, 4095));
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_cycle%0d: got %h required %h", n, obs_vec, exp_vec);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    i_addr_valid = 1'b0; i_dma_complete = 1'b0; i_last_ready = 1'b1;
    i_addr_data = '0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_fill();
    test_backpressure();
    test_errors();
    test_reset_mid_packet();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/last_beat_tagger.md
LAST_BEAT_TAGGER -- requirements
Module: last_beat_tagger

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, width of beat address.
REQ-002 SHALL have parameter BASE_ADDR, default 0, address of first RX buffer.
REQ-003 SHALL have parameter BUF_STRIDE, default 2048, bytes between RX buffer starts; power of two, at least 4.
REQ-004 SHALL have parameter NUM_BUFS, default 1, number of RX buffers, at least 1; NUM_BUFS*BUF_STRIDE at most 2^ADDR_WIDTH.
REQ-005 SHALL have parameter CNT_WIDTH, default 2; MAX_OUT = 2^CNT_WIDTH outstanding packets.
REQ-006 SHALL have parameter BEAT_CNT_WIDTH, default 10, width of per-packet beat count.
REQ-007 Ports, one per line:
 clk  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-high
 i_addr_data  in  ADDR_WIDTH  address of AXI write beat
 i_addr_valid  in  1  beat address valid
 i_addr_ready  out  1  beat address accepted
 i_dma_complete  in  1  single-cycle pulse, PS reports one packet DMA done; no backpressure
 o_last  out  1  previous beat was last of packet
 o_last_valid  out  1  o_last/o_pkt_beats valid
 i_last_ready  in  1  downstream accepts o_last
 o_pkt_beats  out  BEAT_CNT_WIDTH  beat count of tied-off packet, valid when o_last=1
 o_err_spurious  out  1  one-cycle pulse, completion with zero outstanding
 o_err_orphan  out  1  one-cycle pulse, non-start beat with zero outstanding
 o_err_overflow  out  1  sticky, completion pending counter saturated

Function
REQ-008 SHALL treat a beat as start when off = (i_addr_data - BASE_ADDR) mod 2^ADDR_WIDTH satisfies off < NUM_BUFS*BUF_STRIDE and off mod BUF_STRIDE == 0.
REQ-009 SHALL keep start_cnt and done_cnt, each CNT_WIDTH+1 bits, wrapping; outstanding = start_cnt - done_cnt, modulo 2^(CNT_WIDTH+1).
REQ-010 SHALL keep pend, CNT_WIDTH+1 bits: +1 the cycle after each i_dma_complete, -1 on each retire; simultaneous +1/-1 leaves it unchanged.
REQ-011 SHALL define slot_free = !o_last_valid || i_last_ready.
REQ-012 SHALL retire a completion when pend != 0 && slot_free; retirement has priority over any beat.
REQ-013 SHALL drive i_addr_ready = slot_free && pend == 0 && outstanding != MAX_OUT, combinationally.
REQ-014 SHALL, on retire with outstanding == 1, increment done_cnt, present o_last=1, o_last_valid=1, o_pkt_beats=cur_beats next cycle, then clear cur_beats.
REQ-015 SHALL, on retire with outstanding >= 2, increment done_cnt and present nothing (late completion; packet already tied off by a later start).
REQ-016 SHALL, on retire with outstanding == 0, leave done_cnt unchanged, present nothing, and pulse o_err_spurious one cycle.
REQ-017 SHALL, on an accepted start beat, increment start_cnt and set cur_beats=1; if outstanding > 0, present o_last=1, o_pkt_beats=prior cur_beats next cycle.
REQ-018 SHALL, on an accepted non-start beat with outstanding > 0, present o_last=0 next cycle and increment cur_beats, saturating at 2^BEAT_CNT_WIDTH-1.
REQ-019 SHALL, on an accepted non-start beat with outstanding == 0, present nothing, leave cur_beats unchanged, and pulse o_err_orphan one cycle.
REQ-020 SHALL hold o_last, o_pkt_beats and o_last_valid stable while o_last_valid && !i_last_ready; o_last_valid clears after acceptance if nothing new is presented.
REQ-021 SHALL hold pend at MAX_OUT if a completion arrives while pend == MAX_OUT, and set o_err_overflow until reset.
REQ-022 SHALL report the same-cycle i_dma_complete and accepted beat as beat first, then completion.
REQ-023 SHALL have 1-cycle latency from accepted beat or retire to o_last_valid, with no bubbles under continuous i_last_ready.

Reset
REQ-024 SHALL, while reset is high and asynchronously on assertion, clear start_cnt, done_cnt, pend, cur_beats, o_last, o_last_valid, o_pkt_beats and all error outputs.
REQ-025 SHALL drop a packet in flight at reset mid-operation; the first beat after reset is handled per REQ-017/REQ-019.
REQ-026 SHALL hold i_addr_ready at 1 during and after reset until state changes, since outstanding=0, pend=0 and o_last_valid=0.

Verification
REQ-027 Single packet, defaults: beats 0x000,0x004,0x008,0x00C, then complete -> o_last=0 three times, then o_last=1 with o_pkt_beats=4.
REQ-028 Back-to-back, NUM_BUFS=2, BUF_STRIDE=0x800: beats 0x000,0x004,0x800,0x804, then two completes -> 0,1(beats=2),0, first complete silent, second o_last=1 with beats=2.
REQ-029 Fill: 4 single-beat packets, no completes -> 4th start accepted, 5th start sees i_addr_ready=0 until one complete retires.
REQ-030 Backpressure: i_last_ready=0 for 5 cycles while a complete pulses -> o_last held stable, i_addr_ready=0, complete retired after release with no loss.
REQ-031 Errors: complete after reset -> o_err_spurious pulse; beat 0x004 after reset -> o_err_orphan pulse; 5 completes while stalled -> o_err_overflow=1.
REQ-032 Reset mid-packet after 2 beats -> all outputs 0 next edge; then beat 0x000 accepted with no o_last_valid.
